// File: rtl/shift_sequencer.sv
// Multi-cycle sequencer for variable-amount 16-bit shifts (LLS/RLS/LAS/RAS),
// one 1-bit step per clock. Optional overflow flag enabled by macro SHIFT_OVF_EN.
module shift_sequencer #(
  parameter int WIDTH = 16,
  parameter int AMT_W = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [AMT_W-1:0] amt,
  input  logic [WIDTH-1:0] A,
  output logic             busy,
  output logic             done,
`ifdef SHIFT_OVF_EN
  output logic             ovf,
`endif
  output logic [WIDTH-1:0] Y
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  localparam logic [1:0] OP_LLS = 2'b00;
  localparam logic [1:0] OP_RLS = 2'b01;
  localparam logic [1:0] OP_LAS = 2'b10;
  localparam logic [1:0] OP_RAS = 2'b11;

  state_t           state, state_nxt;
  logic [WIDTH-1:0] sreg, sreg_step;
  logic [AMT_W-1:0] cnt;
  logic [1:0]       opr;
  logic             accept;
  logic             stepping;
  logic             finishing;

  // NOTE: state registers use non-blocking assignments so every flop samples
  // pre-edge values regardless of process ordering.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  // NOTE: every output of a combinational block gets a default first so no
  // path through the case statement infers a latch.
  always_comb begin
    state_nxt = state;
    accept    = 1'b0;
    unique case (state)
      IDLE: begin
        if (start) begin
          accept    = 1'b1;
          state_nxt = SHIFT;
        end
      end
      SHIFT: begin
        if (cnt == '0) state_nxt = DONE;
      end
      DONE: begin
        accept    = start;
        state_nxt = start ? SHIFT : IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  assign busy      = (state == SHIFT);
  assign done      = (state == DONE);
  assign stepping  = busy && (cnt != '0);
  assign finishing = busy && (cnt == '0);

  always_comb begin
    sreg_step = sreg;
    unique case (opr)
      OP_LLS, OP_LAS: sreg_step = {sreg[WIDTH-2:0], 1'b0};
      OP_RLS:         sreg_step = {1'b0, sreg[WIDTH-1:1]};
      OP_RAS:         sreg_step = {sreg[WIDTH-1], sreg[WIDTH-1:1]};
      default:        sreg_step = sreg;
    endcase
  end

  // NOTE: the working registers are reset too, so an operation cut short by
  // reset leaves nothing behind that could surface later.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sreg <= '0;
      cnt  <= '0;
      opr  <= OP_LLS;
      Y    <= '0;
    end else if (accept) begin
      sreg <= A;
      cnt  <= amt;
      opr  <= op;
    end else if (stepping) begin
      sreg <= sreg_step;
      cnt  <= cnt - 1'b1;
    end else if (finishing) begin
      Y <= sreg;
    end
  end

`ifdef SHIFT_OVF_EN
  logic ovf_flag;

  // Sticky: any LAS step whose top two bits differ flips the sign.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ovf_flag <= 1'b0;
      ovf      <= 1'b0;
    end else if (accept) begin
      ovf_flag <= 1'b0;
    end else if (stepping) begin
      if (opr == OP_LAS && sreg[WIDTH-1] != sreg[WIDTH-2]) ovf_flag <= 1'b1;
    end else if (finishing) begin
      ovf <= ovf_flag;
    end
  end
`endif

endmodule
